// File: rtl/iob_rst_sequencer_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// drop-counter width and saturation value, and small helper functions.
package iob_rst_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_RDY = 2'd0,
        ST_HOLD     = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_e;

    localparam int unsigned DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'hFF;

    // Saturating increment of the drop counter.
    function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] cnt);
        logic [DROP_W-1:0] res;
        if (cnt == DROP_MAX) begin
            res = cnt;
        end else begin
            res = cnt + 8'd1;
        end
        return res;
    endfunction

    // Width of a down/up counter that must hold values 0..limit-1 (never zero bits).
    function automatic int unsigned cnt_width(input int unsigned limit);
        int unsigned w;
        if (limit > 32'd1) begin
            w = $clog2(limit);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/iob_rst_sequencer_sync.sv
// Single-bit multi-flop synchronizer for an asynchronous ready flag.
module iob_rst_sequencer_sync
    import iob_rst_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] stage_q;

    // Shift the raw flag through the synchronizer chain; cleared by reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            stage_q <= {SYNC_STAGES{1'b0}};
        end else begin
            stage_q <= {stage_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_rst_sequencer.sv
// Power-on reset sequencer: waits for all unmasked ready sources, holds, then
// releases domain resets in index order. Optional watchdog: IOB_RST_SEQUENCER_WDOG_EN.
module iob_rst_sequencer
    import iob_rst_sequencer_pkg::*;
#(
    parameter int N_SRC       = 3,
    parameter int N_OUT       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 1024,
    parameter int STEP_CYC    = 16,
    parameter int WDOG_CYC    = 65536
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic [N_SRC-1:0]  ready_i,
    input  logic [N_SRC-1:0]  mask_i,
    output logic [N_OUT-1:0]  rst_o,
    output logic              run_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              timeout_o
);

    localparam int unsigned HOLD_W    = cnt_width(HOLD_CYC);
    localparam int unsigned STEP_W    = cnt_width(STEP_CYC);
    localparam int unsigned IDX_W     = cnt_width(N_OUT);
    localparam int          HOLD_LAST = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || STEP_CYC < 1 || HOLD_CYC < 0 ||
        WDOG_CYC < 1 || N_SRC < 1 || N_OUT < 1) begin : g_param_err
        $error("iob_rst_sequencer: parameter out of legal range");
    end

    logic [N_SRC-1:0]  ready_sync_s;
    logic              all_rdy_s;

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_OUT-1:0]  rst_q, rst_d;
    logic              run_q, run_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        iob_rst_sequencer_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i    (clk_i),
            .resetn_i (resetn_i),
            .d_i      (ready_i[i]),
            .q_o      (ready_sync_s[i])
        );
    end

    // A masked source always counts as ready, so all-masked is ready.
    assign all_rdy_s = &(ready_sync_s | mask_i);

    // Next-state and registered-output logic of the sequencing FSM.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step_d  = step_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        run_d   = run_q;
        drop_d  = drop_q;
        case (state_q)
            ST_WAIT_RDY: begin
                hold_d = {HOLD_W{1'b0}};
                step_d = {STEP_W{1'b0}};
                idx_d  = {IDX_W{1'b0}};
                rst_d  = {N_OUT{1'b1}};
                run_d  = 1'b0;
                if (!all_rdy_s) begin
                    state_d = ST_WAIT_RDY;
                end else if (HOLD_CYC == 0) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!all_rdy_s) begin
                    state_d = ST_WAIT_RDY;
                    hold_d  = {HOLD_W{1'b0}};
                end else if (hold_q == HOLD_W'(HOLD_LAST)) begin
                    state_d = ST_RELEASE;
                    hold_d  = {HOLD_W{1'b0}};
                end else begin
                    hold_d  = hold_q + HOLD_W'(1'b1);
                end
            end
            ST_RELEASE: begin
                // A loss of readiness takes priority over any pending release step.
                if (!all_rdy_s) begin
                    state_d = ST_WAIT_RDY;
                    rst_d   = {N_OUT{1'b1}};
                    run_d   = 1'b0;
                    drop_d  = drop_inc(drop_q);
                    idx_d   = {IDX_W{1'b0}};
                    step_d  = {STEP_W{1'b0}};
                end else if (step_q == {STEP_W{1'b0}}) begin
                    rst_d[idx_q] = 1'b0;
                    step_d       = STEP_W'(STEP_CYC - 1);
                    if (idx_q == IDX_W'(N_OUT - 1)) begin
                        state_d = ST_RUN;
                        run_d   = 1'b1;
                        idx_d   = {IDX_W{1'b0}};
                    end else begin
                        idx_d   = idx_q + IDX_W'(1'b1);
                    end
                end else begin
                    step_d = step_q - STEP_W'(1'b1);
                end
            end
            ST_RUN: begin
                if (!all_rdy_s) begin
                    state_d = ST_WAIT_RDY;
                    rst_d   = {N_OUT{1'b1}};
                    run_d   = 1'b0;
                    drop_d  = drop_inc(drop_q);
                end else begin
                    rst_d   = {N_OUT{1'b0}};
                    run_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_WAIT_RDY;
                rst_d   = {N_OUT{1'b1}};
                run_d   = 1'b0;
            end
        endcase
    end

    // FSM state, counters and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= ST_WAIT_RDY;
            hold_q  <= {HOLD_W{1'b0}};
            step_q  <= {STEP_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            rst_q   <= {N_OUT{1'b1}};
            run_q   <= 1'b0;
            drop_q  <= {DROP_W{1'b0}};
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            run_q   <= run_d;
            drop_q  <= drop_d;
        end
    end

    assign rst_o      = rst_q;
    assign run_o      = run_q;
    assign drop_cnt_o = drop_q;

`ifdef IOB_RST_SEQUENCER_WDOG_EN
    localparam int unsigned WDOG_W = cnt_width(WDOG_CYC);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    // Watchdog runs only while waiting for readiness; leaving for RELEASE clears it.
    always_comb begin
        wdog_d    = {WDOG_W{1'b0}};
        timeout_d = 1'b0;
        if ((state_q == ST_WAIT_RDY || state_q == ST_HOLD) && state_d != ST_RELEASE) begin
            if (wdog_q == WDOG_W'(WDOG_CYC - 1)) begin
                wdog_d    = {WDOG_W{1'b0}};
                timeout_d = 1'b1;
            end else begin
                wdog_d    = wdog_q + WDOG_W'(1'b1);
                timeout_d = 1'b0;
            end
        end else begin
            wdog_d    = {WDOG_W{1'b0}};
            timeout_d = 1'b0;
        end
    end

    // Watchdog counter and timeout pulse register.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            wdog_q    <= {WDOG_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
